iiitb_rtc_disp: RTL and testbench

//  Multiplexed 6-digit seven-segment scanner directly downstream of the RTC core.

---
 rtl/iiitb_rtc_disp.sv | 119 +++++++++++
 tb/tb_iiitb_rtc_disp.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/iiitb_rtc_disp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | iiitb_rtc_disp : 6-digit multiplexed seven-segment scanner for    |
// |                  HH.MM.SS with per-frame snapshot and guard cycles |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module iiitb_rtc_disp #(
  parameter int REFRESH_DIV    = 8,
  parameter int BLANK_CYCLES   = 2,
  parameter bit BLANK_LEADING  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hrm,
  input  logic [3:0] hrl,
  input  logic [3:0] minm,
  input  logic [3:0] minl,
  input  logic [3:0] secm,
  input  logic [3:0] secl,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  typedef enum logic [0:0] {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_e;

  localparam logic [15:0] C_SLOT_LAST = 16'(REFRESH_DIV - 1);
  localparam logic [15:0] C_BLANK_END = 16'(BLANK_CYCLES - 1);
  localparam logic [5:0]  C_AN_LEFT   = 6'b100000;

  state_e      state_q;
  logic [15:0] slot_cnt_q, slot_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  snap_q [6];
  logic [5:0]  an_q;
  logic [6:0]  seg_q;
  logic        dp_q;

  logic        w_slot_wrap;
  logic        w_frame_start;
  logic        w_lead_blank;
  logic        w_dp_slot;
  logic [3:0]  w_digit;
  logic [6:0]  w_seg_dec;
  logic [5:0]  w_an_dec;

  assign w_slot_wrap   = (slot_cnt_q == C_SLOT_LAST);
  assign w_frame_start = (slot_cnt_q == 16'd0) && (idx_q == 3'd0);
  assign w_digit       = snap_q[idx_q];
  assign w_lead_blank  = BLANK_LEADING && (idx_q == 3'd0) && (w_digit == 4'd0);
  assign w_dp_slot     = ((idx_q == 3'd1) || (idx_q == 3'd3)) && !snap_q[5][0];
  assign w_an_dec      = C_AN_LEFT >> idx_q;

  assign slot_cnt_d = w_slot_wrap ? 16'd0 : slot_cnt_q + 16'd1;
  assign idx_d      = !w_slot_wrap ? idx_q : (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

  always_comb begin
    w_seg_dec = 7'h40;
    case (w_digit)
      4'd0: w_seg_dec = 7'h3F;
      4'd1: w_seg_dec = 7'h06;
      4'd2: w_seg_dec = 7'h5B;
      4'd3: w_seg_dec = 7'h4F;
      4'd4: w_seg_dec = 7'h66;
      4'd5: w_seg_dec = 7'h6D;
      4'd6: w_seg_dec = 7'h7D;
      4'd7: w_seg_dec = 7'h07;
      4'd8: w_seg_dec = 7'h7F;
      4'd9: w_seg_dec = 7'h6F;
      default: w_seg_dec = 7'h40;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt_q <= 16'd0;
      idx_q      <= 3'd0;
      state_q    <= ST_BLANK;
      for (int i = 0; i < 6; i++) snap_q[i] <= 4'd0;
      an_q       <= 6'd0;
      seg_q      <= 7'd0;
      dp_q       <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      idx_q      <= idx_d;
      if (w_frame_start) begin
        snap_q[0] <= hrm;
        snap_q[1] <= hrl;
        snap_q[2] <= minm;
        snap_q[3] <= minl;
        snap_q[4] <= secm;
        snap_q[5] <= secl;
      end
      // state flips one edge ahead so DRIVE coincides with slot_cnt >= BLANK_CYCLES
      case (state_q)
        ST_BLANK: if (slot_cnt_q == C_BLANK_END) state_q <= ST_DRIVE;
        ST_DRIVE: if (w_slot_wrap) state_q <= ST_BLANK;
        default:  state_q <= ST_BLANK;
      endcase
      if (state_q == ST_DRIVE && !w_lead_blank) begin
        an_q  <= w_an_dec;
        seg_q <= w_seg_dec;
        dp_q  <= w_dp_slot;
      end else begin
        an_q  <= 6'd0;
        seg_q <= 7'd0;
        dp_q  <= 1'b0;
      end
    end
  end

  assign an  = AN_ACTIVE_LOW  ? ~an_q  : an_q;
  assign seg = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign dp  = SEG_ACTIVE_LOW ? ~dp_q  : dp_q;

endmodule
`default_nettype wire

// File: tb/tb_iiitb_rtc_disp.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for iiitb_rtc_disp: scoreboard of expected {an,seg,dp} per driven cycle,
// plus direct checks of reset levels, polarity and leading-zero options.
module tb_iiitb_rtc_disp;

  logic       clk;
  logic       rst;
  logic [3:0] hrm, hrl, minm, minl, secm, secl;

  logic [6:0] seg_m, seg_p, seg_b;
  logic       dp_m, dp_p, dp_b;
  logic [5:0] an_m, an_p, an_b;

  int checks = 0;
  int errors = 0;
  int unsigned ecnt;
  logic [13:0] exp_q [$];

  iiitb_rtc_disp #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .BLANK_LEADING(1'b1),
                   .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst(rst), .hrm(hrm), .hrl(hrl), .minm(minm), .minl(minl),
    .secm(secm), .secl(secl), .seg(seg_m), .dp(dp_m), .an(an_m));

  iiitb_rtc_disp #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) u_pol (
    .clk(clk), .rst(rst), .hrm(hrm), .hrl(hrl), .minm(minm), .minl(minl),
    .secm(secm), .secl(secl), .seg(seg_p), .dp(dp_p), .an(an_p));

  iiitb_rtc_disp #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .BLANK_LEADING(1'b0),
                   .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) u_bl0 (
    .clk(clk), .rst(rst), .hrm(hrm), .hrl(hrl), .minm(minm), .minl(minl),
    .secm(secm), .secl(secl), .seg(seg_b), .dp(dp_b), .an(an_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) ecnt <= 0;
    else      ecnt <= ecnt + 1;
  end

  // Monitor: every cycle the main DUT lights a digit, it must match the next expectation.
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (an_m != 6'd0) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scan_unexpected: got an=%h seg=%h dp=%b, expected no drive", an_m, seg_m, dp_m);
        end else begin
          logic [13:0] e;
          e = exp_q.pop_front();
          if ({an_m, seg_m, dp_m} !== e) begin
            errors++;
            $display("FAIL scan_pair: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                     an_m, seg_m, dp_m, e[13:8], e[7:1], e[0]);
          end
        end
      end else if (seg_m != 7'd0 || dp_m != 1'b0) begin
        errors++;
        $display("FAIL blank_leak: got seg=%h dp=%b, expected seg=00 dp=0", seg_m, dp_m);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic wait_edge(input int unsigned n);
    while (ecnt < n) @(negedge clk);
  endtask

  task automatic set_time(input logic [3:0] a, b, c, d, e, f);
    hrm = a; hrl = b; minm = c; minl = d; secm = e; secl = f;
  endtask

  task automatic push_digit(input logic [5:0] a, input logic [6:0] s, input logic d, input int n);
    repeat (n) exp_q.push_back({a, s, d});
  endtask

  task automatic push_frame(input logic [6:0] s0, s1, s2, s3, s4, s5,
                            input bit skip0, input bit dpon);
    logic [6:0] s [6];
    logic [5:0] left;
    left = 6'b100000;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3; s[4] = s4; s[5] = s5;
    for (int k = 0; k < 6; k++) begin
      if (!(k == 0 && skip0))
        push_digit(left >> k, s[k], dpon && (k == 1 || k == 3), 6);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    #2 rst = 1'b0;
    #1;
    chk("reset_main", {an_m, seg_m, dp_m}, {6'h00, 7'h00, 1'b0});
    chk("reset_pol",  {an_p, seg_p, dp_p}, {6'h3F, 7'h7F, 1'b1});

    // 12:34:56 held for two frames, then changed mid-frame to 12:35:00
    push_frame(7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 1'b0, 1'b1);
    push_frame(7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    wait_edge(2);
    chk("first_act_pre", {26'd0, an_m}, {26'd0, 6'h00});
    wait_edge(3);
    chk("first_act_main", {an_m, seg_m, dp_m}, {6'h20, 7'h06, 1'b0});
    chk("first_act_pol",  {an_p, seg_p, dp_p}, {6'h1F, 7'h79, 1'b1});

    wait_edge(76);
    set_time(4'd1, 4'd2, 4'd3, 4'd5, 4'd0, 4'd0);
    push_frame(7'h06, 7'h5B, 7'h4F, 7'h6D, 7'h3F, 7'h3F, 1'b0, 1'b1);

    // 07:3C:54 -> leading blank, invalid BCD dash, dp on (secl even)
    wait_edge(100);
    set_time(4'd0, 4'd7, 4'd3, 4'hC, 4'd5, 4'd4);
    push_frame(7'h00, 7'h07, 7'h4F, 7'h40, 7'h6D, 7'h66, 1'b1, 1'b1);

    wait_edge(147);
    chk("no_lead_blank", {an_b, seg_b, dp_b}, {6'h20, 7'h3F, 1'b0});

    // 23:59:05 -> dp off for the whole frame
    wait_edge(150);
    set_time(4'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd5);
    push_frame(7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h3F, 7'h6D, 1'b0, 1'b0);

    // 18:48:08, then reset lands in the third cycle of idx 2 DRIVE of the next frame
    wait_edge(200);
    set_time(4'd1, 4'd8, 4'd4, 4'd8, 4'd0, 4'd8);
    push_frame(7'h06, 7'h7F, 7'h66, 7'h7F, 7'h3F, 7'h7F, 1'b0, 1'b1);
    push_digit(6'h20, 7'h06, 1'b0, 6);
    push_digit(6'h10, 7'h7F, 1'b1, 6);
    push_digit(6'h08, 7'h66, 1'b0, 3);

    wait_edge(309);
    chk("pol_mid_drive", {an_p, seg_p, dp_p}, {6'h37, 7'h19, 1'b1});
    #2 rst = 1'b0;
    #1;
    chk("async_rst_pol",  {an_p, seg_p, dp_p}, {6'h3F, 7'h7F, 1'b1});
    chk("async_rst_main", {an_m, seg_m, dp_m}, {6'h00, 7'h00, 1'b0});

    // fresh snapshot after reset: 19:51:27
    set_time(4'd1, 4'd9, 4'd5, 4'd1, 4'd2, 4'd7);
    push_frame(7'h06, 7'h6F, 7'h6D, 7'h06, 7'h5B, 7'h07, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    wait_edge(2);
    chk("restart_pre_pol", {26'd0, an_p}, {26'd0, 6'h3F});
    wait_edge(3);
    chk("restart_main", {an_m, seg_m, dp_m}, {6'h20, 7'h06, 1'b0});
    chk("restart_pol",  {an_p, seg_p, dp_p}, {6'h1F, 7'h79, 1'b1});

    wait_edge(50);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
